// File: rtl/logic_arbiter_if.sv
// rtl/logic_arbiter_if.sv - request/response bundle between requesters, consumer and the logic arbiter
interface logic_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_A;
  logic [WIDTH-1:0] req0_B;
  logic [3:0]       req0_ctrl;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_A;
  logic [WIDTH-1:0] req1_B;
  logic [3:0]       req1_ctrl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_dout;
  logic             rsp_id;
  logic             rsp_err;
  logic             busy;
  logic [15:0]      op_count;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_ctrl,
    input  req1_valid, req1_A, req1_B, req1_ctrl,
    output req0_ready, req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_dout, rsp_id, rsp_err, busy, op_count
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_ctrl,
    output req1_valid, req1_A, req1_B, req1_ctrl,
    input  req0_ready, req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_dout, rsp_id, rsp_err, busy, op_count
  );
endinterface

// File: rtl/logic_arbiter.sv
// rtl/logic_arbiter.sv - round-robin two-port sequencer for the shared combinational logic unit
module logic_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             grant;
  logic             grant_valid;
  logic [WIDTH-1:0] unit_out;
  logic             unit_err;

  always_comb begin
    unit_out = '0;
    unit_err = 1'b0;
    case (ctrl_q)
      4'b1000: unit_out = a_q & b_q;
      4'b1110: unit_out = a_q | b_q;
      4'b0110: unit_out = a_q ^ b_q;
      4'b0001: unit_out = ~(a_q | b_q);
      4'b1010: unit_out = a_q;
      default: unit_err = 1'b1;
    endcase
  end

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant       = 1'b0;
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    a_d            = a_q;
    b_d            = b_q;
    ctrl_d         = ctrl_q;
    id_d           = id_q;
    dout_d         = dout_q;
    err_d          = err_q;
    valid_d        = valid_q;
    op_count_d     = op_count_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          a_d            = grant ? bus.req1_A : bus.req0_A;
          b_d            = grant ? bus.req1_B : bus.req0_B;
          ctrl_d         = grant ? bus.req1_ctrl : bus.req0_ctrl;
          id_d           = grant;
          last_grant_d   = grant;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        dout_d  = unit_out;
        err_d   = unit_err;
        state_d = RESP;
      end
      RESP: begin
        // First RESP cycle only raises the registered valid, so it is presented two edges after accept.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          valid_d    = 1'b0;
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      id_q         <= 1'b0;
      dout_q       <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      id_q         <= id_d;
      dout_q       <= dout_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_dout  = dout_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// tb/tb_logic_arbiter.sv - directed self-checking bench for logic_arbiter
module tb_logic_arbiter;

  localparam logic [3:0]  OP_AND  = 4'b1000;
  localparam logic [3:0]  OP_OR   = 4'b1110;
  localparam logic [3:0]  OP_XOR  = 4'b0110;
  localparam logic [3:0]  OP_NOR  = 4'b0001;
  localparam logic [3:0]  OP_PASS = 4'b1010;
  localparam logic [31:0] TA      = 32'hF0F0_1234;
  localparam logic [31:0] TB      = 32'h0FF0_FF00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic_arbiter_if #(.WIDTH(32)) bus ();
  logic_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_ctrl = '0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raises one requester, waits for its ready, and returns at the negedge after the accept edge.
  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, output bit ok);
    if (who) begin
      bus.req1_A = a; bus.req1_B = b; bus.req1_ctrl = ctrl; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_A = a; bus.req0_B = b; bus.req0_ctrl = ctrl; bus.req0_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (who ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ok = bus.rsp_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 32'h0) begin errors++; $display("FAIL reset_rsp_dout: got %h expected 00000000", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %h expected 0000", bus.op_count); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies_idle: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL reset_single_req1: got %b expected 01", {bus.req0_ready, bus.req1_ready}); end
    bus.req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_single_and();
    bit ok;
    int lat;
    issue(1'b0, TA, TB, OP_AND, ok);
    checks++; if (!ok) begin errors++; $display("FAIL and_accept: got no ready expected ready within 20 cycles"); end
    wait_rsp(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL and_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL and_latency: got %0d expected 2", lat); end
    checks++; if (bus.rsp_dout !== 32'h00F0_1200) begin errors++; $display("FAIL and_dout: got %h expected 00f01200", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL and_id: got %b expected 0", bus.rsp_id); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL and_err: got %b expected 0", bus.rsp_err); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL and_valid_drop: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL and_op_count: got %0d expected 1", bus.op_count); end
  endtask

  task automatic test_tie_alternate();
    int          n = 0;
    int          both_hi = 0;
    logic [31:0] got_d [4];
    logic        got_id [4];
    apply_reset();
    bus.req0_A = TA; bus.req0_B = TB; bus.req0_ctrl = OP_OR;
    bus.req1_A = TA; bus.req1_B = TB; bus.req1_ctrl = OP_XOR;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both_hi++;
      if (bus.rsp_valid) begin got_d[n] = bus.rsp_dout; got_id[n] = bus.rsp_id; n++; end
      if (n < 4) @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (n !== 4) begin errors++; $display("FAIL tie_rsp_count: got %0d expected 4", n); end
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL tie_both_ready: got %0d cycles expected 0", both_hi); end
    for (int k = 0; k < n; k++) begin
      checks++; if (got_id[k] !== k[0]) begin errors++; $display("FAIL tie_id[%0d]: got %b expected %b", k, got_id[k], k[0]); end
      checks++; if (got_d[k] !== (k[0] ? 32'hFF00_ED34 : 32'hFFF0_FF34)) begin errors++; $display("FAIL tie_dout[%0d]: got %h expected %h", k, got_d[k], (k[0] ? 32'hFF00_ED34 : 32'hFFF0_FF34)); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    apply_reset();
    bus.rsp_ready = 1'b0;
    issue(1'b1, 32'h0, 32'h0, OP_NOR, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no ready expected ready"); end
    wait_rsp(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    bus.req0_A = TA; bus.req0_B = TB; bus.req0_ctrl = OP_AND; bus.req0_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
      checks++; if (bus.rsp_dout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_dout[%0d]: got %h expected ffffffff", c, bus.rsp_dout); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, bus.busy); end
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_readies[%0d]: got %b expected 00", c, {bus.req0_ready, bus.req1_ready}); end
      checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL bp_op_count[%0d]: got %0d expected 0", c, bus.op_count); end
      @(negedge clk);
    end
    checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_id: got %b expected 1", bus.rsp_id); end
    bus.req0_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL bp_op_count_after: got %0d expected 1", bus.op_count); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_err_pass();
    bit ok;
    int lat;
    apply_reset();
    issue(1'b0, TA, TB, 4'b0011, ok);
    wait_rsp(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (bus.rsp_dout !== 32'h0) begin errors++; $display("FAIL err_dout: got %h expected 00000000", bus.rsp_dout); end
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", bus.rsp_err); end
    @(posedge clk); @(negedge clk);
    issue(1'b0, 32'hDEAD_BEEF, TB, OP_PASS, ok);
    wait_rsp(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pass_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (bus.rsp_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pass_dout: got %h expected deadbeef", bus.rsp_dout); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL pass_err: got %b expected 0", bus.rsp_err); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.op_count !== 16'd2) begin errors++; $display("FAIL pass_op_count: got %0d expected 2", bus.op_count); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    issue(1'b0, TA, TB, OP_AND, ok);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_exec: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL mid_op_count: got %0d expected 0", bus.op_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    bus.req0_A = TA; bus.req0_B = TB; bus.req0_ctrl = OP_OR;
    bus.req1_A = TA; bus.req1_B = TB; bus.req1_ctrl = OP_XOR;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_tie_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk); @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(lat, ok);
    checks++; if (bus.rsp_id !== 1'b0 || !ok) begin errors++; $display("FAIL mid_first_id: got %b valid %b expected id 0 valid 1", bus.rsp_id, ok); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    int lat;
    apply_reset();
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    issue(1'b1, TA, TB, OP_XOR, ok);
    wait_rsp(lat, ok);
    @(posedge clk); @(negedge clk);
    checks++; if (bus.op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", bus.op_count); end
    issue(1'b0, TA, TB, OP_AND, ok);
    wait_rsp(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", bus.op_count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_and();
    test_tie_alternate();
    test_backpressure();
    test_err_pass();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Sequencer and two-port arbiter for the shared 32-bit bitwise logic unit (AND/OR/XOR/NOR/pass-A). It accepts operation requests from two independent requesters over valid/ready handshakes and grants the unit round-robin. Each accepted operation runs through a three-state sequence, and the registered result is returned on a single response channel tagged with the requester ID. It sits between the issue stage and the logic unit, so the unit itself stays purely combinational.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the logic unit is instantiated at this width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle when both valid and ready are high.
- req0_A, req0_B  in  WIDTH  requester 0 operands.
- req0_ctrl  in  4  requester 0 op code.
- req1_valid, req1_ready, req1_A, req1_B, req1_ctrl  same as above, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_dout  out  WIDTH  registered result.
- rsp_id  out  1  requester that issued the op (0 or 1).
- rsp_err  out  1  op code was unsupported.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  number of completed responses; wraps 0xFFFF to 0x0000.

## Operation
- Supported op codes:
  - 4'b1000 AND.
  - 4'b1110 OR.
  - 4'b0110 XOR.
  - 4'b0001 NOR.
  - 4'b1010 pass A.
- Any other ctrl value: rsp_dout = 0, rsp_err = 1. A response is still produced and still counted.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: arbitrate. On handshake, capture A, B, ctrl and id into operand registers and go to EXEC. With no valid request, stay in IDLE.
  - EXEC: drive the captured operands into the logic unit and register its output (or 0 with err) into rsp_dout/rsp_err. Go to RESP. Always lasts exactly one cycle.
  - RESP: hold rsp_valid = 1 with rsp_dout, rsp_id and rsp_err stable until rsp_ready = 1. On the handshake edge, op_count increments and the FSM returns to IDLE.
- Arbitration:
  - Grant is computed combinationally in IDLE only.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - last_grant updates only on an accepted request.
- reqX_ready = (state == IDLE) && (grant == X). It depends combinationally on both valids, never on rsp_ready. The two ready signals are never high together.
- Requesters must hold valid and payload stable until accepted. Dropping valid before acceptance is allowed (the request is withdrawn).
- No new request is accepted in the cycle of the response handshake; the earliest next accept is in the following IDLE cycle.

## Timing
- Reset is sampled at the rising edge with rst_n = 0. It applies in any state, including mid-EXEC or mid-RESP, where the in-flight op is discarded and not counted. Reset values:
  - state = IDLE.
  - rsp_valid = 0, rsp_dout = 0, rsp_id = 0, rsp_err = 0.
  - busy = 0, op_count = 0.
  - req0_ready and req1_ready follow from IDLE and the current valids.
  - last_grant = 1, so requester 0 wins the first tie.
- Latency: accept at edge N. EXEC runs during the cycle after N, and rsp_valid rises after edge N+2. With rsp_ready held high, the response handshake is at edge N+3 and the next accept is at edge N+4 at the earliest.
- Minimum period: one op per 4 cycles, with no back-to-back acceptance.
- Backpressure: rsp_valid may remain high indefinitely. Both reqX_ready stay low for the whole time.
- op_count increment at 0xFFFF yields 0x0000 and raises no flag.

## Test plan
- Reset, then req0 issues AND with A = 0xF0F0_1234, B = 0x0FF0_FF00, rsp_ready = 1.
  - Required: rsp_dout = 0x00F0_1200, rsp_id = 0, rsp_err = 0, rsp_valid rises two edges after accept, op_count = 1.
- Both requesters valid continuously, each with the same A/B as above; req0 ctrl = OR, req1 ctrl = XOR.
  - Required: responses alternate 0xFFF0_FF34 (id 0) and 0xFF00_ED34 (id 1), starting with id 0; req0_ready and req1_ready are never high together.
- req1 issues NOR with A = 0, B = 0, and rsp_ready is held low for 10 cycles.
  - Required: rsp_valid stays high and rsp_dout stays 0xFFFF_FFFF throughout, busy = 1, both readies stay 0, op_count increments only after rsp_ready rises.
- req0 issues ctrl = 4'b0011, then pass-A with A = 0xDEAD_BEEF.
  - Required: the first response is dout 0 with err 1, the second is dout 0xDEAD_BEEF with err 0, op_count = 2.
- Reset mid-operation: assert rst_n = 0 for one edge while in EXEC, then release.
  - Required: rsp_valid = 0, op_count = 0, and a subsequent tie grants req0 first.
- Preload 0xFFFE completions (or force), then complete two more.
  - Required: op_count reads 0xFFFF, then 0x0000.
